// File: rtl/enc_pkg.sv
// Shared 8b/10b control symbols and framing states, used by the tx framer and rx deframer.
package enc_pkg;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;

    typedef enum logic [1:0] {IDLE, SOF, DATA, EOF} state_t;
endpackage

// File: rtl/enc_align_timer.sv
// Counts symbols since the last IDLE_K and flags when a comma must be forced.
module enc_align_timer #(
    parameter int ALIGN_PERIOD = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic force_align
);
    localparam int W = $clog2(ALIGN_PERIOD);
    localparam logic [W-1:0] LAST = W'(ALIGN_PERIOD - 1);

    logic [W-1:0] align_cnt;

    // A forced comma always clears, so the count never passes LAST.
    always_ff @(posedge clk) begin
        if (!rst_n)
            align_cnt <= '0;
        else if (clear)
            align_cnt <= '0;
        else
            align_cnt <= align_cnt + 1'b1;
    end

    assign force_align = (align_cnt == LAST);
endmodule

// File: rtl/enc_tx_framer.sv
// Byte-stream to 8b/10b symbol framer: SOF/EOF framing, idle fill, IFG and periodic commas.
module enc_tx_framer
    import enc_pkg::*;
#(
    parameter logic [7:0] IDLE_K       = K28_5,
    parameter logic [7:0] SOF_K        = K27_7,
    parameter logic [7:0] EOF_K        = K29_7,
    parameter int         ALIGN_PERIOD = 256,
    parameter int         IFG_MIN      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] enc_data,
    output logic       enc_k,
    output logic       tx_busy
);
    localparam int GW = $clog2(IFG_MIN + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(IFG_MIN);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    state_t        state, state_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [7:0]    data_nxt;
    logic          k_nxt;
    logic          force_align;
    logic          accept;
    logic          emit_idle;

    enc_align_timer #(.ALIGN_PERIOD(ALIGN_PERIOD)) u_align (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (emit_idle),
        .force_align (force_align)
    );

    assign s_ready   = (state == DATA) && !force_align;
    assign accept    = s_valid && s_ready;
    assign tx_busy   = (state != IDLE);
    assign emit_idle = k_nxt && (data_nxt == IDLE_K);

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        data_nxt  = IDLE_K;
        k_nxt     = 1'b1;
        if (state == IDLE && gap_cnt != '0)
            gap_nxt = gap_cnt - 1'b1;
        // A forced comma replaces whatever this state would emit and holds the state.
        if (!force_align) begin
            case (state)
                // The idle emitted on the SOF decision cycle is the last of the gap,
                // so exactly IFG_MIN idles separate EOF_K from the next SOF_K.
                IDLE: if (s_valid && gap_cnt <= GAP_ONE) state_nxt = SOF;
                SOF: begin
                    data_nxt  = SOF_K;
                    state_nxt = DATA;
                end
                DATA: if (accept) begin
                    data_nxt = s_data;
                    k_nxt    = 1'b0;
                    if (s_last) state_nxt = EOF;
                end
                EOF: begin
                    data_nxt  = EOF_K;
                    gap_nxt   = GAP_LOAD;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gap_cnt  <= GAP_LOAD;
            enc_data <= IDLE_K;
            enc_k    <= 1'b1;
        end else begin
            state    <= state_nxt;
            gap_cnt  <= gap_nxt;
            enc_data <= data_nxt;
            enc_k    <= k_nxt;
        end
    end
endmodule

// File: tb/tb_enc_tx_framer.sv
// Scenario bench for enc_tx_framer: byte scoreboard plus per-scenario symbol-sequence checks.
module tb_enc_tx_framer;
    localparam int AP = 8;
    localparam logic [7:0] BC = 8'hBC;
    localparam logic [7:0] FB = 8'hFB;
    localparam logic [7:0] FD = 8'hFD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] enc_data;
    logic       enc_k;
    logic       tx_busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [8:0] sym_q[$];
    bit mon_en = 1'b0;
    int run = 0;

    always #5 clk = ~clk;

    enc_tx_framer #(.ALIGN_PERIOD(AP), .IFG_MIN(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .enc_data (enc_data),
        .enc_k    (enc_k),
        .tx_busy  (tx_busy)
    );

    // Output monitor: data bytes come off the scoreboard, K codes must be legal, comma spacing bounded.
    always @(negedge clk) begin
        if (mon_en) begin
            sym_q.push_back({enc_k, enc_data});
            checks++;
            if (enc_k === 1'b1) begin
                if (!(enc_data inside {BC, FB, FD})) begin
                    errors++;
                    $display("FAIL k_code got=%h want=BC/FB/FD", enc_data);
                end
            end else if (enc_k === 1'b0) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte got=%h want=none", enc_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (enc_data !== e) begin
                        errors++;
                        $display("FAIL byte_order got=%h want=%h", enc_data, e);
                    end
                end
            end else begin
                errors++;
                $display("FAIL enc_k_x got=%b want=0/1", enc_k);
            end
            run = (enc_k === 1'b1 && enc_data === BC) ? 0 : run + 1;
            checks++;
            if (run > AP - 1) begin
                errors++;
                $display("FAIL comma_spacing run=%0d want<=%0d", run, AP - 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int find_sym(input logic [8:0] s, input int from);
        for (int i = from; i < sym_q.size(); i++)
            if (sym_q[i] === s) return i;
        return -1;
    endfunction

    // Present one byte and hold it until the framer accepts it; lows counts cycles s_ready was 0.
    task automatic drive_byte(input logic [7:0] d, input logic last, output int lows);
        bit acc = 1'b0;
        int n = 0;
        lows = 0;
        s_data = d;
        s_last = last;
        s_valid = 1'b1;
        exp_q.push_back(d);
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = (s_ready === 1'b1);
            if (!acc) lows++;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout byte=%h cycles=%0d", d, n);
        end else begin
            checks++;
            if (enc_data !== d || enc_k !== 1'b0) begin
                errors++;
                $display("FAIL latency got=%h k=%b want=%h k=0", enc_data, enc_k, d);
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_valid = 1'b0;
        wait_cycles(2);
        checks++;
        if (enc_data !== BC || enc_k !== 1'b1 || s_ready !== 1'b0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got=%h k=%b rdy=%b busy=%b want=bc k=1 rdy=0 busy=0",
                     enc_data, enc_k, s_ready, tx_busy);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (enc_data !== BC || enc_k !== 1'b1 || s_ready !== 1'b0 || tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL idle[%0d] got=%h k=%b rdy=%b busy=%b want=bc k=1 rdy=0 busy=0",
                         c, enc_data, enc_k, s_ready, tx_busy);
            end
        end
        wait_cycles(1);
    endtask

    task automatic test_frame();
        int lw, i;
        logic [8:0] want[8];
        want = '{{1'b1, FB}, {1'b0, 8'h11}, {1'b0, 8'h22}, {1'b0, 8'h33},
                 {1'b0, 8'h44}, {1'b1, FD}, {1'b1, BC}, {1'b1, BC}};
        sym_q.delete();
        drive_byte(8'h11, 1'b0, lw);
        drive_byte(8'h22, 1'b0, lw);
        drive_byte(8'h33, 1'b0, lw);
        drive_byte(8'h44, 1'b1, lw);
        s_valid = 1'b0;
        s_last = 1'b0;
        wait_cycles(6);
        i = find_sym({1'b1, FB}, 0);
        checks++;
        if (i < 1 || sym_q[i-1] !== {1'b1, BC}) begin
            errors++;
            $display("FAIL frame_pre_idle sof_at=%0d want>=1 preceded by bc", i);
        end else begin
            for (int k = 0; k < 8; k++) begin
                logic [8:0] got;
                got = (i + k < sym_q.size()) ? sym_q[i+k] : 9'h000;
                checks++;
                if (got !== want[k]) begin
                    errors++;
                    $display("FAIL frame_seq[%0d] got=%h want=%h", k, got, want[k]);
                end
            end
        end
        checks++;
        if (tx_busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_end busy=%b pending=%0d want busy=0 pending=0", tx_busy, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int lw, m, gaps;
        bit bad;
        sym_q.delete();
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < 3; b++)
                drive_byte(8'hA0 + 8'(f * 16 + b), (b == 2), lw);
        s_valid = 1'b0;
        s_last = 1'b0;
        wait_cycles(6);
        gaps = 0;
        for (int p = 0; p < sym_q.size(); p++) begin
            if (sym_q[p] === {1'b1, FD}) begin
                m = find_sym({1'b1, FB}, p);
                if (m >= 0) begin
                    gaps++;
                    bad = (m - p - 1 != 2);
                    for (int q = p + 1; q < m; q++)
                        if (sym_q[q] !== {1'b1, BC}) bad = 1'b1;
                    checks++;
                    if (bad) begin
                        errors++;
                        $display("FAIL ifg gap=%0d want=2 idles", m - p - 1);
                    end
                end
            end
        end
        checks++;
        if (gaps != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_frames gaps=%0d pending=%0d want gaps=2 pending=0", gaps, exp_q.size());
        end
    endtask

    task automatic test_fill();
        int lw, i;
        logic [8:0] want[9];
        want = '{{1'b1, FB}, {1'b0, 8'h11}, {1'b0, 8'h22}, {1'b1, BC}, {1'b1, BC},
                 {1'b1, BC}, {1'b0, 8'h33}, {1'b0, 8'h44}, {1'b1, FD}};
        sym_q.delete();
        drive_byte(8'h11, 1'b0, lw);
        drive_byte(8'h22, 1'b0, lw);
        s_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready[%0d] got=%b want=1", c, s_ready);
            end
            @(posedge clk);
            #1;
        end
        drive_byte(8'h33, 1'b0, lw);
        drive_byte(8'h44, 1'b1, lw);
        s_valid = 1'b0;
        s_last = 1'b0;
        wait_cycles(6);
        i = find_sym({1'b1, FB}, 0);
        checks++;
        if (i < 0) begin
            errors++;
            $display("FAIL fill_sof got=none want=fb");
        end else begin
            for (int k = 0; k < 9; k++) begin
                logic [8:0] got;
                got = (i + k < sym_q.size()) ? sym_q[i+k] : 9'h000;
                checks++;
                if (got !== want[k]) begin
                    errors++;
                    $display("FAIL fill_seq[%0d] got=%h want=%h", k, got, want[k]);
                end
            end
        end
    endtask

    task automatic test_align();
        int lw, lows, i, n;
        logic [8:0] want[25];
        // With AP=8 at most 7 non-comma symbols run: FB+6 bytes, 7 bytes, 7 bytes, then FD.
        n = 0;
        want[n++] = {1'b1, FB};
        for (int b = 1; b <= 20; b++) begin
            want[n++] = {1'b0, 8'(b)};
            if (b == 6 || b == 13 || b == 20) want[n++] = {1'b1, BC};
        end
        want[n++] = {1'b1, FD};
        sym_q.delete();
        lows = 0;
        for (int b = 1; b <= 20; b++) begin
            drive_byte(8'(b), (b == 20), lw);
            if (b > 1) lows += lw;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        wait_cycles(8);
        checks++;
        if (lows != 2) begin
            errors++;
            $display("FAIL align_ready_lows got=%0d want=2", lows);
        end
        i = find_sym({1'b1, FB}, 0);
        checks++;
        if (i < 0) begin
            errors++;
            $display("FAIL align_sof got=none want=fb");
        end else begin
            for (int k = 0; k < 25; k++) begin
                logic [8:0] got;
                got = (i + k < sym_q.size()) ? sym_q[i+k] : 9'h000;
                checks++;
                if (got !== want[k]) begin
                    errors++;
                    $display("FAIL align_seq[%0d] got=%h want=%h", k, got, want[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lw, fb, fd, i;
        logic [8:0] want[4];
        want = '{{1'b1, FB}, {1'b0, 8'hAA}, {1'b0, 8'hBB}, {1'b1, FD}};
        drive_byte(8'h11, 1'b0, lw);
        drive_byte(8'h22, 1'b0, lw);
        drive_byte(8'h33, 1'b0, lw);
        s_data = 8'h44;
        s_last = 1'b1;
        rst_n = 1'b0;
        wait_cycles(1);
        sym_q.delete();
        checks++;
        if (enc_data !== BC || enc_k !== 1'b1 || tx_busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got=%h k=%b busy=%b rdy=%b want=bc k=1 busy=0 rdy=0",
                     enc_data, enc_k, tx_busy, s_ready);
        end
        rst_n = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        wait_cycles(4);
        drive_byte(8'hAA, 1'b0, lw);
        drive_byte(8'hBB, 1'b1, lw);
        s_valid = 1'b0;
        s_last = 1'b0;
        wait_cycles(6);
        fb = find_sym({1'b1, FB}, 0);
        fd = find_sym({1'b1, FD}, 0);
        checks++;
        if (fb < 0 || (fd >= 0 && fd < fb)) begin
            errors++;
            $display("FAIL mid_no_eof fb_at=%0d fd_at=%0d want fb before fd", fb, fd);
        end else begin
            for (int k = 0; k < 4; k++) begin
                logic [8:0] got;
                i = fb + k;
                got = (i < sym_q.size()) ? sym_q[i] : 9'h000;
                checks++;
                if (got !== want[k]) begin
                    errors++;
                    $display("FAIL mid_seq[%0d] got=%h want=%h", k, got, want[k]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_pending got=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_fill();
        test_align();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
